// File: rtl/result_uploader_pkg.sv
// Shared constants, state encodings and helpers for the result-matrix uploader.
package result_uploader_pkg;

    localparam int N       = 2;
    localparam int C       = 8;
    localparam int RAM_LAT = 2;
    localparam int SEG_W   = 7;
    localparam int IDX_W   = (N > 1) ? $clog2(N) : 1;
    localparam int LAT_W   = (RAM_LAT > 1) ? $clog2(RAM_LAT + 1) : 1;

    localparam bit BYTE_ORDER_MSB_FIRST = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_WAIT,
        ST_SEND,
        ST_NEXT,
        ST_DONE
    } upl_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_SEND,
        TX_WAIT
    } tx_state_t;

    function automatic logic [7:0] pick_byte(input logic [31:0] word, input logic [1:0] k);
        logic [1:0] idx;
        idx = BYTE_ORDER_MSB_FIRST ? (2'd3 - k) : k;
        return word[int'(idx) * 8 +: 8];
    endfunction

    // One-hot read enable for bank [i][j]; bit i*N+j matches packed [i][j] indexing.
    function automatic logic [N*N-1:0] bank_sel(input logic [IDX_W-1:0] i, input logic [IDX_W-1:0] j);
        logic [N*N-1:0] sel;
        sel = '0;
        sel[int'(i) * N + int'(j)] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/result_uploader_fp_word_tx.sv
// Sends one 32-bit word as four UART bytes, one send pulse per byte, paced by tx_done.
module fp_word_tx
    import result_uploader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] word,
    input  logic        tx_done,
    output logic [7:0]  tx_data,
    output logic        send,
    output logic        busy,
    output logic        word_done
);

    tx_state_t  state;
    logic [1:0] k;

    // word must stay stable from load until word_done; it is not copied here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= TX_IDLE;
            k         <= 2'd0;
            tx_data   <= 8'd0;
            send      <= 1'b0;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            send      <= 1'b0;
            word_done <= 1'b0;
            unique case (state)
                TX_IDLE: begin
                    if (load) begin
                        k       <= 2'd0;
                        tx_data <= pick_byte(word, 2'd0);
                        send    <= 1'b1;
                        busy    <= 1'b1;
                        state   <= TX_SEND;
                    end
                end
                TX_SEND: state <= TX_WAIT;
                TX_WAIT: begin
                    if (tx_done) begin
                        if (k != 2'd3) begin
                            k       <= k + 2'd1;
                            tx_data <= pick_byte(word, k + 2'd1);
                            send    <= 1'b1;
                            state   <= TX_SEND;
                        end else begin
                            busy      <= 1'b0;
                            word_done <= 1'b1;
                            state     <= TX_IDLE;
                        end
                    end
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/result_uploader.sv
// Streams the banked result matrix row-major to the UART, four bytes per float.
//   state   | meaning
//   IDLE    | waiting for calc_done; latches segment counts
//   RD      | address and single-bank rden presented
//   WAIT    | RAM latency; captures q on the last cycle
//   SEND    | word handed to fp_word_tx, waiting for its four bytes
//   NEXT    | advance j, wb, i, ra; detect the final element
//   DONE    | final element sent; upload_done pulses next cycle
module result_uploader
    import result_uploader_pkg::*;
(
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       calc_done,
    input  logic [SEG_W-1:0]           a_seg_cnt,
    input  logic [SEG_W-1:0]           w_seg_cnt,
    input  logic [N-1:0][N-1:0][31:0]  ram_c_data_out,
    output logic [N-1:0][N-1:0][C-1:0] ram_c_addr,
    output logic [N-1:0][N-1:0]        ram_c_rden,
    output logic [7:0]                 uart_tx_data,
    output logic                       uart_send_data,
    input  logic                       uart_tx_done,
    output logic                       upload_working,
    output logic                       upload_done
);

    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N - 1);

    upl_state_t       state;
    logic [SEG_W-1:0] a_seg, w_seg, ra, wb, nxt_ra, nxt_wb;
    logic [IDX_W-1:0] i_idx, j_idx, nxt_i, nxt_j;
    logic [C-1:0]     row_base, nxt_base, nxt_addr;
    logic [LAT_W-1:0] lat_cnt;
    logic [31:0]      word_q;
    logic             load, tx_busy, word_done, last_elem;

    // row_base tracks ra*w_seg incrementally so no multiplier is needed.
    always_comb begin
        nxt_ra    = ra;
        nxt_wb    = wb;
        nxt_i     = i_idx;
        nxt_j     = j_idx;
        nxt_base  = row_base;
        last_elem = 1'b0;
        if (a_seg == '0 || w_seg == '0) begin
            last_elem = 1'b1;
        end else if (j_idx != IDX_MAX) begin
            nxt_j = j_idx + IDX_W'(1);
        end else begin
            nxt_j = '0;
            if (wb != w_seg - SEG_W'(1)) begin
                nxt_wb = wb + SEG_W'(1);
            end else begin
                nxt_wb = '0;
                if (i_idx != IDX_MAX) begin
                    nxt_i = i_idx + IDX_W'(1);
                end else begin
                    nxt_i = '0;
                    if (ra != a_seg - SEG_W'(1)) begin
                        nxt_ra   = ra + SEG_W'(1);
                        nxt_base = row_base + C'(w_seg);
                    end else begin
                        last_elem = 1'b1;
                    end
                end
            end
        end
    end

    assign nxt_addr = nxt_base + C'(nxt_wb);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            a_seg          <= '0;
            w_seg          <= '0;
            ra             <= '0;
            wb             <= '0;
            i_idx          <= '0;
            j_idx          <= '0;
            row_base       <= '0;
            lat_cnt        <= '0;
            word_q         <= '0;
            load           <= 1'b0;
            ram_c_addr     <= '0;
            ram_c_rden     <= '0;
            upload_working <= 1'b0;
            upload_done    <= 1'b0;
        end else begin
            load        <= 1'b0;
            upload_done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    upload_working <= 1'b0;
                    if (calc_done) begin
                        a_seg          <= a_seg_cnt;
                        w_seg          <= w_seg_cnt;
                        ra             <= '0;
                        wb             <= '0;
                        i_idx          <= '0;
                        j_idx          <= '0;
                        row_base       <= '0;
                        upload_working <= 1'b1;
                        // Empty matrix still walks through NEXT so the done pulse keeps a fixed latency.
                        if (a_seg_cnt == '0 || w_seg_cnt == '0) begin
                            state <= ST_NEXT;
                        end else begin
                            ram_c_addr <= '0;
                            ram_c_rden <= bank_sel('0, '0);
                            state      <= ST_RD;
                        end
                    end
                end
                ST_RD: begin
                    lat_cnt <= LAT_W'(RAM_LAT - 1);
                    state   <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end else begin
                        word_q     <= ram_c_data_out[i_idx][j_idx];
                        ram_c_rden <= '0;
                        load       <= 1'b1;
                        state      <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (word_done && !tx_busy) state <= ST_NEXT;
                end
                ST_NEXT: begin
                    ra       <= nxt_ra;
                    wb       <= nxt_wb;
                    i_idx    <= nxt_i;
                    j_idx    <= nxt_j;
                    row_base <= nxt_base;
                    if (last_elem) begin
                        state <= ST_DONE;
                    end else begin
                        ram_c_addr <= {(N*N){nxt_addr}};
                        ram_c_rden <= bank_sel(nxt_i, nxt_j);
                        state      <= ST_RD;
                    end
                end
                ST_DONE: begin
                    upload_done <= 1'b1;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    fp_word_tx u_word_tx (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .word      (word_q),
        .tx_done   (uart_tx_done),
        .tx_data   (uart_tx_data),
        .send      (uart_send_data),
        .busy      (tx_busy),
        .word_done (word_done)
    );

endmodule

// File: tb/tb_result_uploader.sv
// Self-checking bench for result_uploader: banked RAM model, UART responder and byte-order reference.
module tb_result_uploader;
    import result_uploader_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic                       calc_done = 1'b0;
    logic                       uart_tx_done = 1'b0;
    logic [SEG_W-1:0]           a_seg_cnt = '0;
    logic [SEG_W-1:0]           w_seg_cnt = '0;
    logic [N-1:0][N-1:0][31:0]  ram_q;
    logic [N-1:0][N-1:0][31:0]  ram_stage;
    logic [N-1:0][N-1:0][C-1:0] ram_c_addr;
    logic [N-1:0][N-1:0]        ram_c_rden;
    logic [7:0]                 uart_tx_data;
    logic                       uart_send_data;
    logic                       upload_working;
    logic                       upload_done;

    int         checks = 0;
    int         errors = 0;
    logic [31:0] mem [N][N][256];
    logic [7:0]  exp_q [$];

    result_uploader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .calc_done      (calc_done),
        .a_seg_cnt      (a_seg_cnt),
        .w_seg_cnt      (w_seg_cnt),
        .ram_c_data_out (ram_q),
        .ram_c_addr     (ram_c_addr),
        .ram_c_rden     (ram_c_rden),
        .uart_tx_data   (uart_tx_data),
        .uart_send_data (uart_send_data),
        .uart_tx_done   (uart_tx_done),
        .upload_working (upload_working),
        .upload_done    (upload_done)
    );

    always #5 clk = ~clk;

    // Two-stage registered RAM: q is valid RAM_LAT cycles after address/rden.
    always @(posedge clk) begin
        for (int bi = 0; bi < N; bi++) begin
            for (int bj = 0; bj < N; bj++) begin
                if (ram_c_rden[bi][bj]) ram_stage[bi][bj] <= mem[bi][bj][ram_c_addr[bi][bj]];
                ram_q[bi][bj] <= ram_stage[bi][bj];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fill_random();
        for (int bi = 0; bi < N; bi++)
            for (int bj = 0; bj < N; bj++)
                for (int ad = 0; ad < 256; ad++)
                    mem[bi][bj][ad] = $urandom;
    endtask

    // Reference: walk the result matrix row-major and emit each float MSB first.
    task automatic build_expected(input int a, input int w);
        exp_q.delete();
        for (int row = 0; row < a * N; row++) begin
            for (int col = 0; col < w * N; col++) begin
                int          ad;
                logic [31:0] v;
                ad = ((row / N) * w + (col / N)) % 256;
                v  = mem[row % N][col % N][ad];
                for (int k = 0; k < 4; k++) exp_q.push_back(v[31 - 8 * k -: 8]);
            end
        end
    endtask

    function automatic int tx_delay(input int mode, input int k);
        if (mode == 0) return 0;
        if (mode == 1) return int'($urandom_range(0, 3));
        return (k % 3 == 0) ? 0 : ((k % 3 == 1) ? 1 : 50);
    endfunction

    task automatic run_upload(input string name, input int a, input int w, input int mode, input int abort_at);
        int         rel, n, wt, d;
        logic [7:0] b;
        bit         stable, extra;
        build_expected(a, w);
        n = exp_q.size();
        a_seg_cnt = SEG_W'(a);
        w_seg_cnt = SEG_W'(w);
        calc_done = 1'b1;
        @(negedge clk);
        calc_done = 1'b0;
        rel = 1;
        a_seg_cnt = SEG_W'($urandom);
        w_seg_cnt = SEG_W'($urandom);
        check({name, " working_after_start"}, 64'(upload_working), 64'(1));
        if (n > 0) begin
            check({name, " first_addr"}, 64'(ram_c_addr), 64'(0));
            for (int c = 0; c <= RAM_LAT; c++) begin
                check({name, " rden_bank00"}, 64'(ram_c_rden), 64'(1));
                uart_tx_done = (mode == 2 && c == 1);
                @(negedge clk);
                rel++;
            end
            uart_tx_done = 1'b0;
            check({name, " rden_dropped"}, 64'(ram_c_rden), 64'(0));
        end
        for (int k = 0; k < n; k++) begin
            wt = 0;
            while (!uart_send_data && wt < 300) begin
                @(negedge clk);
                wt++;
                rel++;
            end
            check({name, " send_seen"}, 64'(uart_send_data), 64'(1));
            if (!uart_send_data) return;
            if (k == 0) check({name, " first_send_latency"}, 64'(rel), 64'(RAM_LAT + 3));
            check({name, " byte"}, 64'(uart_tx_data), 64'(exp_q[k]));
            b = uart_tx_data;
            if (abort_at == k + 1) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check({name, " outputs_after_reset"},
                      64'({uart_send_data, uart_tx_data, ram_c_rden, ram_c_addr, upload_working, upload_done}), 64'(0));
                extra = 1'b0;
                for (int c = 0; c < 40; c++) begin
                    if (upload_done || uart_send_data || upload_working) extra = 1'b1;
                    @(negedge clk);
                end
                check({name, " quiet_after_abort"}, 64'(extra), 64'(0));
                return;
            end
            @(negedge clk);
            check({name, " send_one_cycle"}, 64'(uart_send_data), 64'(0));
            d = tx_delay(mode, k);
            stable = 1'b1;
            for (int c = 0; c < d; c++) begin
                if (uart_tx_data !== b || uart_send_data) stable = 1'b0;
                calc_done = (mode == 2 && k == 5 && c == 10);
                @(negedge clk);
            end
            calc_done = 1'b0;
            check({name, " data_stable_in_stall"}, 64'(stable), 64'(1));
            uart_tx_done = 1'b1;
            @(negedge clk);
            uart_tx_done = 1'b0;
            rel++;
        end
        wt = 0;
        extra = 1'b0;
        while (!upload_done && wt < 50) begin
            if (uart_send_data) extra = 1'b1;
            @(negedge clk);
            wt++;
            rel++;
        end
        check({name, " done_seen"}, 64'(upload_done), 64'(1));
        check({name, " no_extra_send"}, 64'(extra), 64'(0));
        check({name, " working_at_done"}, 64'(upload_working), 64'(1));
        if (n == 0) check({name, " empty_done_latency"}, 64'(rel), 64'(3));
        @(negedge clk);
        check({name, " done_one_cycle"}, 64'(upload_done), 64'(0));
        check({name, " working_cleared"}, 64'(upload_working), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset outputs",
              64'({uart_send_data, uart_tx_data, ram_c_rden, ram_c_addr, upload_working, upload_done}), 64'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("idle no working", 64'(upload_working), 64'(0));

        // Scenario 1: known floats at address 0, immediate tx_done.
        fill_random();
        mem[0][0][0] = 32'h3F80_0000;
        mem[0][1][0] = 32'h4000_0000;
        mem[1][0][0] = 32'h4040_0000;
        mem[1][1][0] = 32'h4080_0000;
        run_upload("s1", 1, 1, 0, 0);

        // Scenario 2: each word encodes its bank and address.
        for (int bi = 0; bi < N; bi++)
            for (int bj = 0; bj < N; bj++)
                for (int ad = 0; ad < 256; ad++)
                    mem[bi][bj][ad] = {8'(bi), 8'(bj), 8'h00, 8'(ad)};
        run_upload("s2", 2, 2, 1, 0);

        // Scenario 3: empty matrices.
        run_upload("s3a", 0, 3, 1, 0);
        run_upload("s3b", 2, 0, 1, 0);

        // Scenario 4: long stalls, stray tx_done and a second calc_done mid-transfer.
        fill_random();
        run_upload("s4", 1, 1, 2, 0);

        // Scenario 5: reset after byte 5, then clean restart.
        fill_random();
        run_upload("s5abort", 1, 2, 1, 5);
        run_upload("s5restart", 1, 1, 1, 0);

        // Randomised sizes and contents.
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_upload("rand", int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
